serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_ctrl_if.sv | 30 +++
 rtl/serial_add_ctrl.sv | 129 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/serial_add_ctrl_if.sv
// Operation request/result bus of serial_add_ctrl plus its link to the external 4-bit adder slice.
// slave = sequencer side, master = requester/slice side.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic [3:0]       slice_a;
  logic [3:0]       slice_b;
  logic             slice_ci;
  logic [3:0]       slice_s;
  logic             slice_co;

  modport slave (
    input  start, sub, a, b, slice_s, slice_co,
    output busy, done, result, cout, ovf, slice_a, slice_b, slice_ci
  );

  modport master (
    output start, sub, a, b, slice_s, slice_co,
    input  busy, done, result, cout, ovf, slice_a, slice_b, slice_ci
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Nibble-serial add/subtract over one external 4-bit adder slice: WIDTH/4 RUN cycles, done at cycle NIB+1.
// No backpressure: start is only sampled while idle and is dropped (never queued) while busy.
module serial_add_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  serial_add_ctrl_if.slave  bus
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic             accept;
  logic             last;
  logic             in_run;

  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry_r;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nx;
  logic [3:0]       nib_a;
  logic [3:0]       nib_b;

  logic [WIDTH-1:0] result_r;
  logic             cout_r;
  logic             ovf_r;
  logic             ovf_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    last     = (idx == LAST_IDX);
    in_run   = (state == RUN);
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept   = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (last) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Nibble select of the operands and the accumulator write-back for the current step.
  always_comb begin
    nib_a  = 4'b0;
    nib_b  = 4'b0;
    acc_nx = acc;
    for (int i = 0; i < NIB; i++) begin
      if (idx == IDXW'(i)) begin
        nib_a            = a_r[4*i +: 4];
        nib_b            = b_r[4*i +: 4];
        acc_nx[4*i +: 4] = bus.slice_s;
      end
    end
  end

  // Operands share the sign bit with the slice result of the top nibble.
  assign ovf_nx = (a_r[WIDTH-1] == b_r[WIDTH-1]) & (bus.slice_s[3] != a_r[WIDTH-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r      <= '0;
      b_r      <= '0;
      carry_r  <= 1'b0;
      idx      <= '0;
      acc      <= '0;
      result_r <= '0;
      cout_r   <= 1'b0;
      ovf_r    <= 1'b0;
    end else if (accept) begin
      a_r     <= bus.a;
      b_r     <= bus.sub ? ~bus.b : bus.b;
      carry_r <= bus.sub;
      idx     <= '0;
    end else if (in_run) begin
      acc     <= acc_nx;
      carry_r <= bus.slice_co;
      idx     <= last ? '0 : idx + IDXW'(1);
      if (last) begin
        result_r <= acc_nx;
        cout_r   <= bus.slice_co;
        ovf_r    <= ovf_nx;
      end
    end
  end

  assign bus.slice_a  = in_run ? nib_a : 4'b0;
  assign bus.slice_b  = in_run ? nib_b : 4'b0;
  assign bus.slice_ci = in_run ? carry_r : 1'b0;

  assign bus.busy   = (state != IDLE);
  assign bus.done   = (state == DONE);
  assign bus.result = result_r;
  assign bus.cout   = cout_r;
  assign bus.ovf    = ovf_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl with a behavioural adder slice and an arithmetic reference model.
module tb_serial_add_ctrl;

  localparam int WIDTH = 32;
  localparam int NIB   = WIDTH / 4;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             co;
    logic             ov;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // External adder slice
  logic [4:0] slice_sum;
  assign slice_sum    = {1'b0, bus.slice_a} + {1'b0, bus.slice_b} + {4'b0, bus.slice_ci};
  assign bus.slice_s  = slice_sum[3:0];
  assign bus.slice_co = slice_sum[4];

  int   vectors = 0;
  int   fails   = 0;
  exp_t sb_q[$];

  // Reference model state
  int               cnt = 0;
  logic [WIDTH-1:0] m_a = '0;
  logic [WIDTH-1:0] m_b = '0;
  logic             m_sub = 1'b0;
  exp_t             m_exp = '0;
  exp_t             m_out = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic exp_t ref_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
    exp_t   r;
    longint sa, sb, sr, lim;
    sa    = longint'($signed(a));
    sb    = longint'($signed(b));
    sr    = s ? sa - sb : sa + sb;
    lim   = longint'(1) << (WIDTH - 1);
    r.res = s ? a - b : a + b;
    r.co  = s ? (a >= b) : ((longint'(a) + longint'(b)) >= (longint'(1) << WIDTH));
    r.ov  = (sr >= lim) || (sr < -lim);
    return r;
  endfunction

  // Expected {slice_a, slice_b, slice_ci} while processing nibble j.
  function automatic logic [8:0] slice_ref(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                           input logic s, input int j);
    logic [63:0]      m, al, bl;
    logic [WIDTH-1:0] ta, tb;
    logic             ci;
    m  = (64'd1 << (4 * j)) - 64'd1;
    al = 64'(a) & m;
    bl = 64'(b) & m;
    if (j == 0)  ci = s;
    else if (s)  ci = (al >= bl);
    else         ci = (((al + bl) >> (4 * j)) != 64'd0);
    ta = a >> (4 * j);
    tb = (s ? ~b : b) >> (4 * j);
    return {ta[3:0], tb[3:0], ci};
  endfunction

  // Model: advances on each rising edge from the inputs the bench applied.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        cnt   = 0;
        m_out = '0;
        sb_q.delete();
      end else if (cnt == 0) begin
        if (bus.start) begin
          m_a   = bus.a;
          m_b   = bus.b;
          m_sub = bus.sub;
          m_exp = ref_op(bus.a, bus.b, bus.sub);
          sb_q.push_back(m_exp);
          cnt   = NIB + 1;
        end
      end else begin
        cnt--;
        if (cnt == 1) m_out = m_exp;
      end
    end
  end

  // Monitor: samples DUT outputs mid-cycle.
  initial begin
    logic [8:0] sl_exp;
    exp_t       e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("busy", 64'(bus.busy), 64'(cnt > 0));
      chk("done", 64'(bus.done), 64'(cnt == 1));
      chk("held_outputs", 64'({bus.result, bus.cout, bus.ovf}), 64'(m_out));
      sl_exp = (cnt >= 2) ? slice_ref(m_a, m_b, m_sub, NIB + 1 - cnt) : 9'd0;
      chk("slice_ports", 64'({bus.slice_a, bus.slice_b, bus.slice_ci}), 64'(sl_exp));
      if (bus.done) begin
        chk("sb_pending", 64'(sb_q.size() > 0), 64'd1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          chk("sb_result", 64'(bus.result), 64'(e.res));
          chk("sb_cout", 64'(bus.cout), 64'(e.co));
          chk("sb_ovf", 64'(bus.ovf), 64'(e.ov));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [WIDTH-1:0] da [5] = '{32'h0000_0001, 32'h7FFF_FFFF, 32'h0000_0005, 32'h8000_0000, 32'h1234_5678};
  logic [WIDTH-1:0] db [5] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0007, 32'h0000_0001, 32'h0000_0000};
  logic             ds [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    rst       = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (6) tick();

    // Directed cases; operands are scrambled right after acceptance.
    for (int i = 0; i < 5; i++) begin
      bus.a = da[i]; bus.b = db[i]; bus.sub = ds[i]; bus.start = 1'b1;
      tick();
      bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom; bus.sub = 1'($urandom);
      repeat (NIB + 2) tick();
    end

    // Reset in cycle 4 of an operation, then a clean operation.
    bus.a = $urandom; bus.b = $urandom; bus.sub = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    bus.a = $urandom; bus.b = $urandom; bus.sub = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (NIB + 2) tick();

    // start held high with operands changing every cycle.
    bus.start = 1'b1;
    repeat (45) begin
      bus.a = $urandom; bus.b = $urandom; bus.sub = 1'($urandom);
      tick();
    end
    bus.start = 1'b0;
    repeat (NIB + 2) tick();

    // Random traffic with occasional resets.
    repeat (800) begin
      bus.a     = $urandom;
      bus.b     = ($urandom_range(0, 7) == 0) ? {WIDTH{1'b1}} : $urandom;
      bus.sub   = 1'($urandom);
      bus.start = ($urandom_range(0, 2) == 0);
      rst       = ($urandom_range(0, 59) == 0);
      tick();
    end
    rst = 1'b0;
    bus.start = 1'b0;
    repeat (NIB + 3) tick();

    chk("drain", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
